// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode/state enums, data width and opcode legality helper for the ULA arbiter
package ula_pkg;
  localparam int DW = 8;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4
  } op_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_NOT;
  endfunction
endpackage

// File: rtl/ula_8_bits_structure.sv
// ula_8_bits_structure: combinational 8-bit ALU (ADD/SUB with carry/borrow, AND, OR, NOT)
module ula_8_bits_structure
  import ula_pkg::*;
(
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          cin_i,
  output logic [DW-1:0] s_o,
  output logic          cout_o
);
  logic [DW:0] sum, dif;
  assign sum = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, cin_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i} - {{DW{1'b0}}, cin_i};
  assign s_o = op_i == OP_ADD ? sum[DW-1:0] :
               op_i == OP_SUB ? dif[DW-1:0] :
               op_i == OP_AND ? a_i & b_i :
               op_i == OP_OR  ? a_i | b_i :
               op_i == OP_NOT ? ~a_i : '0;
  assign cout_o = op_i == OP_ADD ? sum[DW] : op_i == OP_SUB ? dif[DW] : 1'b0;
endmodule

// File: rtl/ula_arbiter_8_bits.sv
// ula_arbiter_8_bits: two-requester round-robin front end to one ALU, one transaction in flight (optional RSP_ZERO via ULA_ARBITER_ZERO_FLAG_EN)
module ula_arbiter_8_bits
  import ula_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [1:0][2:0]      REQ_OP,
  input  logic [1:0][DW-1:0]   REQ_A,
  input  logic [1:0][DW-1:0]   REQ_B,
  input  logic [1:0]           REQ_CIN,
  output logic [1:0]           RSP_VALID,
  input  logic [1:0]           RSP_READY,
  output logic [DW-1:0]        RSP_S,
  output logic                 RSP_COUT,
  output logic                 RSP_ERR
`ifdef ULA_ARBITER_ZERO_FLAG_EN
  ,
  output logic                 RSP_ZERO
`endif
);
  state_t state_q, state_d;
  logic last_q, idx_q, gnt, accept, done, illegal, cin_q, cout_q, err_q, alu_cout;
  logic [2:0] op_q;
  logic [DW-1:0] a_q, b_q, s_q, alu_s;
  assign gnt = &REQ_VALID ? ~last_q : REQ_VALID[1];
  assign accept = state_q == ST_IDLE && |REQ_VALID;
  assign done = state_q == ST_RESP && RSP_READY[idx_q];
  assign REQ_READY = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_VALID = state_q == ST_RESP ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_S = s_q;
  assign RSP_COUT = cout_q;
  assign RSP_ERR = err_q;
  assign illegal = op_illegal(op_q);
  ula_8_bits_structure u_alu (
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .s_o    (alu_s),
    .cout_o (alu_cout)
  );
  // next state: accept -> execute for one cycle -> hold response until the addressed requester takes it
  always_comb
    state_d = accept ? ST_EXEC : state_q == ST_EXEC ? ST_RESP : done ? ST_IDLE : state_q;
`ifdef ULA_ARBITER_ZERO_FLAG_EN
  logic zero_q;
  assign RSP_ZERO = zero_q;
  // zero flag is registered alongside the result so it changes only when RSP_S does
  always_ff @(posedge CLK)
    if (RST) zero_q <= 1'b0;
    else if (state_q == ST_EXEC) zero_q <= ~illegal & ~|alu_s;
`endif
  // state, grant history, latched request and registered result
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= ST_IDLE;
      last_q <= 1'b1;
      idx_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      s_q <= '0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= gnt;
        last_q <= gnt;
        op_q <= REQ_OP[gnt];
        a_q <= REQ_A[gnt];
        b_q <= REQ_B[gnt];
        cin_q <= REQ_CIN[gnt];
      end
      if (state_q == ST_EXEC) begin
        s_q <= illegal ? '0 : alu_s;
        cout_q <= ~illegal & alu_cout;
        err_q <= illegal;
      end
    end
endmodule
